odu_mchan_gen_fifo: RTL and testbench

Multi-channel successor to the single-channel ODU count/generate/FIFO block. NUM_CH independent paced ODU test-word generators, each with its own rate type, frame position and MFAS, share one datapath through a round-robin arbiter. Granted words are tagged with channel ID and buffered in one parametrised synchronous FIFO read by the downstream framer/checker. Per-channel overrun flags report pacing ticks lost to backpressure.

---
 rtl/odu_gen_pkg.sv | 35 +++
 rtl/odu_sync_fifo.sv | 57 +++++
 rtl/odu_mchan_gen_fifo.sv | 172 +++++++++++++++++
 tb/tb_odu_mchan_gen_fifo.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/odu_gen_pkg.sv
// Shared widths, PRBS31 constants and entry header type for the multi-channel ODU generator.
// Optional macro: ODU_GEN_PRBS_EN (PRBS31 payload instead of the replicated sequence word).
package odu_gen_pkg;

  localparam int MFAS_W = 8;
  localparam int SEQ_W  = 16;

  // PRBS31 x^31 + x^28 + 1: feedback taps on state bits 30 and 27
  localparam logic [30:0] PRBS_SEED  = 31'h7FFF_FFFF;
  localparam int          PRBS_TAP_A = 30;
  localparam int          PRBS_TAP_B = 27;

  typedef struct packed {
    logic              frame_start;
    logic              row_start;
    logic [MFAS_W-1:0] mfas;
  } odu_hdr_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int ch_w(input int num_ch);
    return clog2_min1(num_ch);
  endfunction

  function automatic int entry_w(input int num_ch, input int data_width);
    return ch_w(num_ch) + 2 + MFAS_W + data_width;
  endfunction

  function automatic logic [30:0] prbs31_step(input logic [30:0] s);
    return {s[29:0], s[PRBS_TAP_A] ^ s[PRBS_TAP_B]};
  endfunction

endpackage

// File: rtl/odu_sync_fifo.sv
// Synchronous FIFO with registered read data and an occupancy counter.
module odu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  // Handshake: a write is taken when wr_en && !full, a read when rd_en && !empty;
  // requests outside those conditions are dropped without side effects.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;
  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      rd_data <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/odu_mchan_gen_fifo.sv
// NUM_CH paced ODU test-word generators sharing one FIFO through a round-robin arbiter.
// Optional macro: ODU_GEN_PRBS_EN selects a per-channel PRBS31 payload.
module odu_mchan_gen_fifo
  import odu_gen_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int DATA_WIDTH    = 384,
  parameter int FIFO_DEPTH    = 8,
  parameter int WORDS_PER_ROW = 80,
  parameter int ROWS          = 4,
  parameter int PERIOD0       = 4,
  parameter int PERIOD1       = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_CH-1:0]                        enable_ch,
  input  logic [NUM_CH-1:0]                        type_ch,
  input  logic                                     fifo_read_enable,
  output logic                                     fifo_empty,
  output logic                                     fifo_full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]          fifo_level,
  output logic [entry_w(NUM_CH, DATA_WIDTH)-1:0]   fifo_data_out,
  output logic                                     mon_valid,
  output logic [ch_w(NUM_CH)-1:0]                  mon_ch,
  output logic [DATA_WIDTH-1:0]                    mon_data,
  output logic [NUM_CH-1:0]                        overrun_ch
);

  localparam int CH_W    = ch_w(NUM_CH);
  localparam int ENTRY_W = entry_w(NUM_CH, DATA_WIDTH);
  localparam int PMAX    = (PERIOD0 > PERIOD1) ? PERIOD0 : PERIOD1;
  localparam int CNT_W   = $clog2(PMAX);
  localparam int COL_W   = clog2_min1(WORDS_PER_ROW);
  localparam int ROW_W   = clog2_min1(ROWS);

  logic [CNT_W-1:0]  cnt     [NUM_CH];
  logic [CNT_W-1:0]  reload  [NUM_CH];
  logic [COL_W-1:0]  col     [NUM_CH];
  logic [ROW_W-1:0]  row     [NUM_CH];
  logic [MFAS_W-1:0] mfas    [NUM_CH];
  logic [SEQ_W-1:0]  seq     [NUM_CH];
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] grant_hit;
  logic [CH_W-1:0]   rr_ptr;
  logic              grant_vld;
  logic [CH_W-1:0]   grant_ch;
  odu_hdr_t          hdr;
  logic [DATA_WIDTH-1:0] payload;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      reload[i]    = type_ch[i] ? CNT_W'(PERIOD1-1) : CNT_W'(PERIOD0-1);
      tick[i]      = enable_ch[i] && (cnt[i] == '0);
      grant_hit[i] = grant_vld && (grant_ch == CH_W'(i));
    end
  end

  // Scan from the highest offset down so the channel closest to rr_ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    for (int k = NUM_CH-1; k >= 0; k--) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NUM_CH;
      if (pending[idx] && !fifo_full) begin
        grant_vld = 1'b1;
        grant_ch  = CH_W'(idx);
      end
    end
  end

  always_comb begin
    hdr             = '0;
    hdr.row_start   = (col[grant_ch] == '0);
    hdr.frame_start = (col[grant_ch] == '0) && (row[grant_ch] == '0);
    hdr.mfas        = mfas[grant_ch];
  end

`ifdef ODU_GEN_PRBS_EN
  logic [30:0] prbs [NUM_CH];
  logic [30:0] prbs_nxt;

  // First generated bit lands in the payload MSB.
  always_comb begin
    prbs_nxt = prbs[grant_ch];
    payload  = '0;
    for (int b = DATA_WIDTH-1; b >= 0; b--) begin
      prbs_nxt   = prbs31_step(prbs_nxt);
      payload[b] = prbs_nxt[0];
    end
  end
`else
  always_comb payload = {(DATA_WIDTH/SEQ_W){seq[grant_ch]}};
`endif

  assign mon_valid = grant_vld;
  assign mon_ch    = grant_ch;
  assign mon_data  = payload;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      overrun_ch <= '0;
      pending    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]  <= reload[i];
        col[i]  <= '0;
        row[i]  <= '0;
        mfas[i] <= '0;
        seq[i]  <= '0;
`ifdef ODU_GEN_PRBS_EN
        prbs[i] <= PRBS_SEED;
`endif
      end
    end else begin
      if (grant_vld) rr_ptr <= (grant_ch == CH_W'(NUM_CH-1)) ? '0 : grant_ch + 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (!enable_ch[i]) begin
          cnt[i]     <= reload[i];
          pending[i] <= 1'b0;
          col[i]     <= '0;
          row[i]     <= '0;
          mfas[i]    <= '0;
          seq[i]     <= '0;
`ifdef ODU_GEN_PRBS_EN
          prbs[i]    <= PRBS_SEED;
`endif
        end else begin
          cnt[i] <= tick[i] ? reload[i] : cnt[i] - 1'b1;
          // A tick landing on an ungranted pending word is a lost word.
          if (tick[i]) pending[i] <= 1'b1;
          else if (grant_hit[i]) pending[i] <= 1'b0;
          if (tick[i] && pending[i] && !grant_hit[i]) overrun_ch[i] <= 1'b1;
          if (grant_hit[i]) begin
            seq[i] <= seq[i] + 1'b1;
`ifdef ODU_GEN_PRBS_EN
            prbs[i] <= prbs_nxt;
`endif
            if (col[i] == COL_W'(WORDS_PER_ROW-1)) begin
              col[i] <= '0;
              if (row[i] == ROW_W'(ROWS-1)) begin
                row[i]  <= '0;
                mfas[i] <= mfas[i] + 1'b1;
              end else begin
                row[i] <= row[i] + 1'b1;
              end
            end else begin
              col[i] <= col[i] + 1'b1;
            end
          end
        end
      end
    end
  end

  odu_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (grant_vld),
    .wr_data ({grant_ch, hdr, payload}),
    .rd_en   (fifo_read_enable),
    .rd_data (fifo_data_out),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_odu_mchan_gen_fifo.sv
// Directed bench for odu_mchan_gen_fifo: pacing, round-robin, FIFO backpressure/overrun, framing, reset.
module tb_odu_mchan_gen_fifo;

  localparam int NUM_CH  = 4;
  localparam int DW      = 384;
  localparam int DEPTH   = 8;
  localparam int CH_W    = 2;
  localparam int ENTRY_W = CH_W + 2 + 8 + DW;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_CH-1:0]  enable_ch;
  logic [NUM_CH-1:0]  type_ch;
  logic               fifo_read_enable;
  logic               fifo_empty;
  logic               fifo_full;
  logic [3:0]         fifo_level;
  logic [ENTRY_W-1:0] fifo_data_out;
  logic               mon_valid;
  logic [CH_W-1:0]    mon_ch;
  logic [DW-1:0]      mon_data;
  logic [NUM_CH-1:0]  overrun_ch;

  int n_checks = 0;
  int n_fail   = 0;
  logic [ENTRY_W-1:0] exp_q[$];

  odu_mchan_gen_fifo #(
    .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
    .WORDS_PER_ROW(80), .ROWS(4), .PERIOD0(4), .PERIOD1(16)
  ) dut (
    .clk(clk), .rst(rst), .enable_ch(enable_ch), .type_ch(type_ch),
    .fifo_read_enable(fifo_read_enable), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_level(fifo_level), .fifo_data_out(fifo_data_out), .mon_valid(mon_valid),
    .mon_ch(mon_ch), .mon_data(mon_data), .overrun_ch(overrun_ch)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_mon(input string tag, input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!mon_valid && n < max);
    check(tag, 512'(mon_valid), 512'(1));
  endtask

  // Reference payload of the n-th word a channel produces since reset/enable.
  function automatic logic [DW-1:0] exp_payload(input int n);
    logic [DW-1:0] p;
`ifdef ODU_GEN_PRBS_EN
    bit b[];
    int base;
    b = new[31 + (n+1)*DW];
    for (int i = 0; i < 31; i++) b[i] = 1'b1;
    for (int i = 31; i < b.size(); i++) b[i] = b[i-31] ^ b[i-28];
    base = 31 + n*DW;
    for (int j = 0; j < DW; j++) p[DW-1-j] = b[base+j];
`else
    logic [15:0] s;
    s = n[15:0];
    p = {(DW/16){s}};
`endif
    return p;
  endfunction

  function automatic logic [ENTRY_W-1:0] exp_entry(input int ch, input bit fs, input bit rs,
                                                   input int mf, input int n);
    logic [1:0] c;
    logic [7:0] m;
    c = ch[1:0];
    m = mf[7:0];
    return {c, fs, rs, m, exp_payload(n)};
  endfunction

  initial begin
    int n;
    int wr;
    int w;
    int chk_w;
    int chk_at;
    bit done;

    rst = 1'b1;
    enable_ch = '0;
    type_ch = '0;
    fifo_read_enable = 1'b0;
    repeat (3) step();
    check("rst_empty",   512'(fifo_empty),    512'(1));
    check("rst_full",    512'(fifo_full),     512'(0));
    check("rst_level",   512'(fifo_level),    512'(0));
    check("rst_dout",    512'(fifo_data_out), 512'(0));
    check("rst_mon",     512'(mon_valid),     512'(0));
    check("rst_overrun", 512'(overrun_ch),    512'(0));
    rst = 1'b0;
    step();

    // Single channel, type0, no reads: pacing, fill to full, overrun, one slot freed.
    enable_ch = 4'b0001;
    wait_mon("t1_first", 20, n);
    check("t1_latency", 512'(n), 512'(4));
    check("t1_ch", 512'(mon_ch), 512'(0));
    check("t1_data0", 512'(mon_data), 512'(exp_payload(0)));
    wait_mon("t1_second", 20, n);
    check("t1_period", 512'(n), 512'(4));
    check("t1_data1", 512'(mon_data), 512'(exp_payload(1)));
    check("t1_level1", 512'(fifo_level), 512'(1));
    check("t1_not_empty", 512'(fifo_empty), 512'(0));
    for (int k = 2; k < 8; k++) begin
      wait_mon("t1_word", 20, n);
      check("t1_seq", 512'(mon_data), 512'(exp_payload(k)));
    end
    step();
    check("t1_full", 512'(fifo_full), 512'(1));
    check("t1_level8", 512'(fifo_level), 512'(8));
    repeat (3) step();
    check("t1_blocked", 512'(mon_valid), 512'(0));
    check("t1_no_overrun_yet", 512'(overrun_ch), 512'(0));
    repeat (4) step();
    check("t1_overrun", 512'(overrun_ch), 512'(4'b0001));
    fifo_read_enable = 1'b1;
    step();
    fifo_read_enable = 1'b0;
    check("t1_level7", 512'(fifo_level), 512'(7));
    check("t1_refill", 512'(mon_valid), 512'(1));
    check("t1_refill_seq8", 512'(mon_data), 512'(exp_payload(8)));
    check("t1_dout0", 512'(fifo_data_out), 512'(exp_entry(0, 1, 1, 0, 0)));
    wr = 1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (mon_valid) wr++;
    end
    check("t1_one_write", 512'(wr), 512'(1));

    // Disable mid-frame and drain the remaining eight entries.
    enable_ch = '0;
    fifo_read_enable = 1'b1;
    for (int s = 1; s <= 8; s++) begin
      step();
      check("t1_drain", 512'(fifo_data_out), 512'(exp_entry(0, 0, 0, 0, s)));
    end
    fifo_read_enable = 1'b0;
    check("t1_drained_empty", 512'(fifo_empty), 512'(1));
    check("t1_sticky_overrun", 512'(overrun_ch), 512'(4'b0001));

    // Re-enable: frame position and sequence restart.
    enable_ch = 4'b0001;
    wait_mon("t3_first", 20, n);
    check("t3_seq0", 512'(mon_data), 512'(exp_payload(0)));
    step();
    fifo_read_enable = 1'b1;
    step();
    fifo_read_enable = 1'b0;
    check("t3_frame_start", 512'(fifo_data_out), 512'(exp_entry(0, 1, 1, 0, 0)));
    n = 0;
    while (fifo_level != 4'd5 && n < 100) begin
      step();
      n++;
    end
    check("t3_level5", 512'(fifo_level), 512'(5));
    rst = 1'b1;
    enable_ch = '0;
    step();
    check("t3_rst_empty",   512'(fifo_empty),    512'(1));
    check("t3_rst_level",   512'(fifo_level),    512'(0));
    check("t3_rst_overrun", 512'(overrun_ch),    512'(0));
    check("t3_rst_dout",    512'(fifo_data_out), 512'(0));
    rst = 1'b0;
    repeat (2) step();

    // All channels type0, continuous reads: strict rotation, no overrun.
    enable_ch = 4'b1111;
    fifo_read_enable = 1'b1;
    wait_mon("t2_first", 20, n);
    check("t2_latency", 512'(n), 512'(4));
    for (int k = 0; k < 12; k++) begin
      if (k > 0) step();
      check("t2_valid", 512'(mon_valid), 512'(1));
      check("t2_ch", 512'(mon_ch), 512'(k % 4));
      check("t2_data", 512'(mon_data), 512'(exp_payload(k / 4)));
      exp_q.push_back(exp_entry(k % 4, k < 4, k < 4, 0, k / 4));
      if (k >= 1) check("t2_level", 512'(fifo_level), 512'(1));
      if (k >= 2) check("t2_dout", 512'(fifo_data_out), 512'(exp_q.pop_front()));
    end
    check("t2_no_overrun", 512'(overrun_ch), 512'(0));
    enable_ch = '0;
    fifo_read_enable = 1'b0;
    exp_q.delete();

    // Channel 1 type1 over one full frame: row and frame markers, MFAS step.
    rst = 1'b1;
    step();
    rst = 1'b0;
    type_ch = 4'b0010;
    step();
    enable_ch = 4'b0010;
    fifo_read_enable = 1'b1;
    w = 0;
    chk_w = 0;
    chk_at = -1;
    done = 1'b0;
    for (int s = 0; s < 6000 && !done; s++) begin
      step();
      if (s == chk_at && (chk_w == 0 || chk_w == 79 || chk_w == 80 || chk_w == 320)) begin
        check("t4_entry", 512'(fifo_data_out),
              512'(exp_entry(1, (chk_w % 320) == 0, (chk_w % 80) == 0, chk_w / 320, chk_w)));
        if (chk_w == 320) done = 1'b1;
      end
      if (mon_valid) begin
        if (w == 0) check("t4_ch", 512'(mon_ch), 512'(1));
        chk_w = w;
        chk_at = s + 2;
        w++;
      end
    end
    check("t4_frame_done", 512'(done), 512'(1));
    check("t4_no_overrun", 512'(overrun_ch), 512'(0));
    enable_ch = '0;
    fifo_read_enable = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
